// File: rtl/one_hot_register_bank.sv
// ----------------------------------------------------------------------------
// one_hot_register_bank
//
// Eight-entry general-purpose register bank for the MCU datapath. It takes one
// write port addressed by a one-hot enable vector coming straight from the
// 3-to-8 write-address decoder. It has two independent binary-addressed read
// ports that feed the ALU operand muxes. R0 is hardwired to zero.
// Multi-hot write vectors are rejected and recorded in a sticky error flag.
//
// Optional feature (compile-time macro REGBANK_BYPASS_EN):
//   When defined, a read port whose address matches the target of a
//   qualified single-hot write in the current cycle returns wr_data
//   combinationally (write-through forwarding). When not defined, reads
//   return stored contents only.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset (registers, wr_err, wr_count)
//   wr_onehot  in   [NUM_REGS-1:0]      one-hot write enable, all-zero = idle
//   wr_data    in   [BUS_WIDTH-1:0]     write data
//   rd_addr_a  in   [ADDRESS_WIDTH-1:0] read port A address
//   rd_addr_b  in   [ADDRESS_WIDTH-1:0] read port B address
//   rd_data_a  out  [BUS_WIDTH-1:0]     read port A data (combinational)
//   rd_data_b  out  [BUS_WIDTH-1:0]     read port B data (combinational)
//   wr_err     out  sticky flag, a multi-hot write vector was seen
//   wr_count   out  [7:0] committed writes since reset, saturating at 8'hFF
//
// NUM_REGS must equal 2**ADDRESS_WIDTH so every read address maps to an entry.
// ----------------------------------------------------------------------------
module one_hot_register_bank #(
    parameter int BUS_WIDTH     = 8,
    parameter int ADDRESS_WIDTH = 3,
    parameter int NUM_REGS      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REGS-1:0]      wr_onehot,
    input  logic [BUS_WIDTH-1:0]     wr_data,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr_a,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr_b,
    output logic [BUS_WIDTH-1:0]     rd_data_a,
    output logic [BUS_WIDTH-1:0]     rd_data_b,
    output logic                     wr_err,
    output logic [7:0]               wr_count
);

    // Storage. Entry 0 is never written and reads are forced to zero, so it
    // stays a constant-zero register.
    logic [BUS_WIDTH-1:0]     regs_q [NUM_REGS];
    logic [BUS_WIDTH-1:0]     regs_d [NUM_REGS];
    logic                     wr_err_q, wr_err_d;
    logic [7:0]               wr_count_q, wr_count_d;

    // Write qualification signals
    logic [NUM_REGS-1:0]      eff;
    logic                     wr_single;
    logic                     wr_multi;
    logic [ADDRESS_WIDTH-1:0] wr_idx;

    // Bit 0 is dropped so a stray R0 enable is just "no write".
    // (x & (x-1)) == 0 tests for at most one bit set.
    always_comb begin
        eff       = {wr_onehot[NUM_REGS-1:1], 1'b0};
        wr_single = (eff != '0) && ((eff & (eff - NUM_REGS'(1))) == '0);
        wr_multi  = (eff != '0) && !wr_single;
    end

    // One-hot to binary index. The result only matters when wr_single is set.
    always_comb begin
        wr_idx = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (eff[i]) begin
                wr_idx = ADDRESS_WIDTH'(i);
            end
        end
    end

    always_comb begin
        regs_d     = regs_q;
        wr_err_d   = wr_err_q | wr_multi;
        wr_count_d = wr_count_q;
        if (wr_single) begin
            regs_d[wr_idx] = wr_data;
            if (wr_count_q != 8'hFF) begin
                wr_count_d = wr_count_q + 8'd1;
            end
        end
    end

    // Reset wins over a coincident write: the write is simply dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            wr_err_q   <= 1'b0;
            wr_count_q <= 8'd0;
        end else begin
            regs_q     <= regs_d;
            wr_err_q   <= wr_err_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Read ports. Address 0 always returns zero.
`ifdef REGBANK_BYPASS_EN
    // wr_idx is never 0 when wr_single is set, so R0 never forwards. Multi-hot
    // vectors never forward either.
    logic fwd_ok;
    assign fwd_ok = wr_single && !rst;

    always_comb begin
        if (rd_addr_a == '0) begin
            rd_data_a = '0;
        end else if (fwd_ok && (rd_addr_a == wr_idx)) begin
            rd_data_a = wr_data;
        end else begin
            rd_data_a = regs_q[rd_addr_a];
        end

        if (rd_addr_b == '0) begin
            rd_data_b = '0;
        end else if (fwd_ok && (rd_addr_b == wr_idx)) begin
            rd_data_b = wr_data;
        end else begin
            rd_data_b = regs_q[rd_addr_b];
        end
    end
`else
    always_comb begin
        rd_data_a = (rd_addr_a == '0) ? '0 : regs_q[rd_addr_a];
        rd_data_b = (rd_addr_b == '0) ? '0 : regs_q[rd_addr_b];
    end
`endif

    assign wr_err   = wr_err_q;
    assign wr_count = wr_count_q;

endmodule

// File: doc/one_hot_register_bank.md
Name: one_hot_register_bank

Overview:
- Eight-entry general-purpose register bank for the MCU datapath.
- Sits directly downstream of the 3-to-8 write-address decoder and consumes its one-hot write-enable vector; bit 0 never asserts from the decoder.
- One write port driven by the one-hot vector. Two independent read ports with 3-bit binary addresses feed the ALU operand muxes.
- R0 is hardwired to zero. The bank also flags illegal (multi-hot) write-enable vectors.

Parameters:
- BUS_WIDTH, 8, data width of each register and of all data ports
- ADDRESS_WIDTH, 3, width of read addresses
- NUM_REGS, 8, register count; must equal 2**ADDRESS_WIDTH

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- wr_onehot  input  NUM_REGS  one-hot write-enable vector from decoder; all-zero means no write
- wr_data  input  BUS_WIDTH  write data
- rd_addr_a  input  ADDRESS_WIDTH  read port A address
- rd_addr_b  input  ADDRESS_WIDTH  read port B address
- rd_data_a  output  BUS_WIDTH  read port A data
- rd_data_b  output  BUS_WIDTH  read port B data
- wr_err  output  1  sticky flag: a multi-hot wr_onehot was presented
- wr_count  output  8  number of committed writes since reset, saturating

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high, sampled on the rising edge of clk.
- Reset: all registers R0..R7 = 0, wr_err = 0, wr_count = 0. Reset has priority over any write in the same cycle; a write coincident with rst is dropped.
- Write qualification, evaluated each rising edge when rst = 0:
  - Effective vector eff = wr_onehot with bit 0 forced to 0.
  - eff == 0: no write, no error.
  - eff has exactly one bit set: register[index] <= wr_data on that edge; wr_count increments.
  - eff has more than one bit set: no register changes, wr_err <= 1, wr_count unchanged.
  - wr_onehot[0] = 1 alone: treated as no write; R0 stays 0 and wr_err is unaffected.
- wr_err: sticky; cleared only by rst.
- wr_count: increments by 1 per committed write and saturates at 8'hFF (no wrap).
- Read ports:
  - Combinational (zero-cycle latency) from rd_addr_x to rd_data_x.
  - Address 0 always returns 0.
  - Both ports may read the same address simultaneously.
  - Read-during-write without bypass returns the pre-edge (old) value until the edge commits.
- Write visibility: a committed write is visible on the read ports in the cycle after the edge.
- Mid-write reset: rst asserted with a valid write yields all-zero registers after that edge.

Optional Feature:
- Macro: REGBANK_BYPASS_EN
- Defined:
  - Each read port compares rd_addr_x against the index of a qualified single-hot eff in the current cycle.
  - On match (address != 0, rst = 0, no multi-hot), rd_data_x = wr_data combinationally, i.e. write-through forwarding in the same cycle.
  - Multi-hot vectors and address 0 never forward.
- Not defined: reads return stored contents only, as described in Behaviour.

Test Plan:
- Reset then read all addresses on both ports -> rd_data_a = rd_data_b = 8'h00; wr_err = 0; wr_count = 0.
- Write 8'hA5 with wr_onehot = 8'b0000_1000, then read rd_addr_a = 3; the same cycle reads 8'hA5 only if REGBANK_BYPASS_EN is defined, otherwise 8'h00 -> next cycle reads 8'hA5; wr_count = 1.
- wr_onehot = 8'b0000_0001 with wr_data = 8'hFF -> R0 reads 8'h00; wr_err = 0; wr_count unchanged.
- wr_onehot = 8'b0110_0000 with wr_data = 8'h3C -> R5 and R6 unchanged; wr_err = 1 and stays 1 across later legal writes until rst.
- Write R7 = 8'h11 and simultaneously assert rst -> R7 reads 8'h00; wr_count = 0.
- 300 consecutive legal writes -> wr_count saturates at 8'hFF; last written register holds the final wr_data.
